ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch stage that sits between the instruction ROM and the execute stage. It owns the fetch PC, issues sequential word requests to the 1-cycle-latency synchronous ROM, and buffers the returned words with their PCs in a small prefetch queue. It presents one instruction and its PC per cycle to execute over a valid/ready handshake. A redirect input from execute, for a taken branch or jump, flushes the queue and any in-flight request and restarts fetch at the redirect target.

## Interface
- DEPTH, 4, number of queue entries; a power of 2 and at least 2
- ADDR_W, 16, ROM byte-address width
- RESET_PC, 32'h00000000, fetch PC loaded on reset
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- rom_en  output  1  request issued this cycle
- rom_addr  output  ADDR_W  byte address, equal to fetch_pc[ADDR_W-1:0]
- rom_data  input  32  ROM word; valid the cycle after rom_en
- redirect  input  1  flush and restart fetch
- redirect_pc  input  32  restart address, sampled when redirect=1
- out_valid  output  1  out_instr and out_pc hold a valid entry
- out_ready  input  1  execute consumes the head entry when out_valid=1
- out_instr  output  32  head instruction; 32'h00000013 (NOP) when out_valid=0
- out_pc  output  32  head PC; 0 when out_valid=0
- count  output  $clog2(DEPTH)+1  current queue occupancy
- misalign  output  1  misaligned-redirect flag; see Configuration

## Operation

**State**
- fetch_pc (32 bits)
- inflight flag, plus inflight_pc
- circular queue of {instr, pc}, with head and tail pointers and count

**Issue**
- rom_en = !rst && !redirect && !misalign && (count + inflight < DEPTH).
- On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
- fetch_pc addition wraps modulo 2^32.
- With no issue: inflight <= 0.

**Push**
- In a cycle with inflight=1 and redirect=0, {rom_data, inflight_pc} is written at the tail.
- The credit rule guarantees the push never overflows.

**Pop**
- When out_valid && out_ready, head advances.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A pop while empty cannot occur because out_valid=0.
- No bypass: a word pushed into an empty queue appears at the output the next cycle.

**Redirect (cycle R)**
- At the edge ending R:
  - count <= 0; pointers reset.
  - inflight <= 0, discarding the ROM response present in R.
  - fetch_pc <= redirect_pc.
- rom_en=0 during R.
- A pop handshake in R is ignored; the queue is flushed regardless.
- Redirect has priority over push, pop and issue.

**Pointer wrap**
- head and tail wrap modulo DEPTH.
- count distinguishes full from empty.

## Timing
- Request issued in cycle T → rom_data valid in T+1 → pushed at the end of T+1 → out_valid in T+2 (fetch-to-output latency 2).
- Redirect in R → first issue in R+1 at redirect_pc → out_valid with out_pc=redirect_pc in R+3.
- Steady state with out_ready held high: one instruction per cycle.
- Reset values (asynchronous, effective immediately):
  - fetch_pc=RESET_PC, inflight=0, count=0, misalign=0
  - out_valid=0, out_instr=32'h00000013, out_pc=0, rom_en=0
- First issue is in the first cycle after rst deasserts, at RESET_PC.
- Reset asserted mid-stream discards all queued and in-flight words.

## Configuration
- Macro: IFETCH_QUEUE_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign=1 at the end of R and loads fetch_pc unchanged.
  - While misalign=1, issue is inhibited, and the queue drains and stays empty.
  - A later redirect with an aligned target clears misalign and resumes normal fetch.
- Undefined:
  - redirect_pc[1:0] is treated as 2'b00.
  - misalign is constant 0.

## Test plan
- Reset release with out_ready=1 and ROM word = address → out_valid first high in cycle 2 after reset; out_pc sequence 0, 4, 8, 12…; out_instr matches the ROM.
- out_ready=0 for 10 cycles → count saturates at DEPTH (4); rom_en low while count + inflight = 4; releasing out_ready delivers PCs in order with none lost or duplicated.
- redirect with redirect_pc=0x40 while the queue holds 3 entries and inflight=1 → next cycle count=0; the stale response is not pushed; the first out_pc is 0x40, 3 cycles after R.
- redirect and out_ready both high in the same cycle with a full queue → queue empty afterwards; the output continues from the redirect target only.
- With the macro defined: redirect to 0x42 → misalign=1, rom_en stays 0, out_valid=0; then redirect to 0x80 → misalign=0 and out_pc=0x80 three cycles later. With the macro undefined, 0x42 fetches from 0x40.
- rst pulsed for 1 cycle mid-stream, at an asynchronous point → outputs immediately return to reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: ROM request/response, redirect from execute, and the
// valid/ready instruction stream toward execute.
interface ifetch_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [CW-1:0]     count;
  logic              misalign;

  modport master (
    output rom_en, rom_addr, out_valid, out_instr, out_pc, count, misalign,
    input  rom_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  rom_en, rom_addr, out_valid, out_instr, out_pc, count, misalign,
    output rom_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch with credit-based ROM issue and a DEPTH-entry prefetch queue.
// Optional IFETCH_QUEUE_ALIGN_CHECK_EN: misaligned redirects halt fetch via misalign.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master fq
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            misalign_q, misalign_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            issue, push, pop, out_valid;
  logic [31:0]     target;
  logic            target_bad;

  always_comb begin
`ifdef IFETCH_QUEUE_ALIGN_CHECK_EN
    target     = fq.redirect_pc;
    target_bad = |fq.redirect_pc[1:0];
`else
    target     = fq.redirect_pc & ~32'h3;
    target_bad = 1'b0;
`endif
  end

  // Credit: a word in flight already owns a queue slot, so push never overflows.
  assign issue     = !rst && !fq.redirect && !misalign_q &&
                     ((count_q + CW'(inflight_q)) < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = inflight_q;
  assign pop       = out_valid && fq.out_ready;

  always_comb begin
    mem_d         = mem_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    misalign_d    = misalign_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (fq.redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = target;
      misalign_d = target_bad;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{instr: fq.rom_data, pc: inflight_pc_q};
        tail_d        = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      misalign_q    <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      mem_q         <= mem_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      misalign_q    <= misalign_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  assign fq.rom_en    = issue;
  assign fq.rom_addr  = fetch_pc_q[ADDR_W-1:0];
  assign fq.out_valid = out_valid;
  assign fq.out_instr = out_valid ? mem_q[head_q].instr : NOP;
  assign fq.out_pc    = out_valid ? mem_q[head_q].pc : 32'h0;
  assign fq.count     = count_q;
  assign fq.misalign  = misalign_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: expected PC stream queued on reset/redirect,
// compared against every presented head entry and popped on each handshake.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(16), .DEPTH(4)) ifq ();

  ifetch_queue #(.DEPTH(4), .ADDR_W(16), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (ifq)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // 1-cycle synchronous ROM
  always @(posedge clk) ifq.rom_data <= rom_word(ifq.rom_addr);

  int          n_vec   = 0;
  int          n_err   = 0;
  int          n_deliv = 0;
  int          d0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 128; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, ifq.out_valid, 0);
    chk({tag, "_instr"}, ifq.out_instr, 32'h13);
    chk({tag, "_pc"},    ifq.out_pc,    0);
    chk({tag, "_rom_en"},ifq.rom_en,    0);
    chk({tag, "_count"}, ifq.count,     0);
    chk({tag, "_mis"},   ifq.misalign,  0);
  endtask

  // One cycle: drive inputs after the edge, then check the presented head.
  task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk); #1;
    ifq.out_ready   = rdy;
    ifq.redirect    = rd;
    ifq.redirect_pc = rpc;
    #1;
    if (ifq.out_valid) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        chk("out_pc",    ifq.out_pc,    exp_q[0]);
        chk("out_instr", ifq.out_instr, rom_word(exp_q[0][15:0]));
        if (rdy && !rd) begin
          void'(exp_q.pop_front());
          n_deliv++;
        end
      end
    end
    if (rd) begin
      chk("redir_rom_en", ifq.rom_en, 0);
`ifdef IFETCH_QUEUE_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) exp_q.delete();
      else fill(rpc);
`else
      fill({rpc[31:2], 2'b00});
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst             = 1'b1;
    ifq.out_ready   = 1'b1;
    ifq.redirect    = 1'b0;
    ifq.redirect_pc = '0;
    #2;
    chk_rst("por");

    // Reset release: latency 2, then one word per cycle
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    fill(32'h0);
    #1;
    chk("t1_issue_en",   ifq.rom_en,   1);
    chk("t1_issue_addr", ifq.rom_addr, 0);
    chk("t1_v0",         ifq.out_valid, 0);
    cyc(1, 0, 0); chk("t1_v1", ifq.out_valid, 0);
    cyc(1, 0, 0); chk("t1_v2", ifq.out_valid, 1);
    d0 = n_deliv;
    repeat (10) cyc(1, 0, 0);
    chk("t1_tput", n_deliv - d0, 10);

    // Back-pressure: fill to DEPTH, credit stops issue, then drain in order
    repeat (10) cyc(0, 0, 0);
    chk("t2_full",   ifq.count,  4);
    chk("t2_credit", ifq.rom_en, 0);
    d0 = n_deliv;
    repeat (20) cyc(1, 0, 0);
    chk("t2_drain", n_deliv - d0, 20);

    // Redirect with 3 queued + 1 in flight
    cyc(0, 1, 32'h100);
    cyc(0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (ifq.count == 3) found = 1'b1;
      else cyc(0, 0, 0);
    end
    chk("t3_fill",   ifq.count,  3);
    chk("t3_credit", ifq.rom_en, 0);
    cyc(0, 1, 32'h40);
    cyc(1, 0, 0); chk("t3_flush", ifq.count, 0); chk("t3_v1", ifq.out_valid, 0);
    cyc(1, 0, 0); chk("t3_v2", ifq.out_valid, 0);
    cyc(1, 0, 0); chk("t3_v3", ifq.out_valid, 1); chk("t3_pc", ifq.out_pc, 32'h40);
    repeat (8) cyc(1, 0, 0);

    // Redirect together with a pop on a full queue
    repeat (8) cyc(0, 0, 0);
    chk("t4_full", ifq.count, 4);
    cyc(1, 1, 32'h200);
    d0 = n_deliv;
    cyc(1, 0, 0); chk("t4_flush", ifq.count, 0);
    repeat (10) cyc(1, 0, 0);
    chk("t4_deliv", n_deliv - d0, 9);

    // Misaligned redirect
    cyc(1, 1, 32'h42);
`ifdef IFETCH_QUEUE_ALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      chk("t5_mis",    ifq.misalign,  1);
      chk("t5_rom_en", ifq.rom_en,    0);
      chk("t5_valid",  ifq.out_valid, 0);
    end
`else
    cyc(1, 0, 0); chk("t5_mis", ifq.misalign, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0); chk("t5_valid", ifq.out_valid, 1); chk("t5_pc", ifq.out_pc, 32'h40);
`endif
    cyc(1, 1, 32'h80);
    cyc(1, 0, 0); chk("t5_clr", ifq.misalign, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0); chk("t5_v80", ifq.out_valid, 1); chk("t5_pc80", ifq.out_pc, 32'h80);
    repeat (5) cyc(1, 0, 0);

    // Async reset pulse mid-cycle
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_rst("t6");
    @(posedge clk); #1;
    rst = 1'b0;
    fill(32'h0);
    #1;
    chk("t6_issue_en",   ifq.rom_en,   1);
    chk("t6_issue_addr", ifq.rom_addr, 0);
    cyc(1, 0, 0); chk("t6_v1", ifq.out_valid, 0);
    cyc(1, 0, 0); chk("t6_v2", ifq.out_valid, 1); chk("t6_pc", ifq.out_pc, 0);
    repeat (6) cyc(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
